// File: rtl/gat_pkg.sv
// Shared GAT accelerator definitions used by the classifier stage.
// Holds default sizes, derived index widths and the argmax FSM state type.
package gat_pkg;

  localparam int DATA_WIDTH         = 32;
  localparam int NUM_FEATURE_OUT    = 16;
  localparam int NUM_SUBGRAPHS      = 2708;
  localparam int BRAM_RD_LAT        = 2;
  localparam int NEW_FEATURE_ADDR_W = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT);
  localparam int CLASS_W            = $clog2(NUM_FEATURE_OUT);
  localparam int NODE_W             = $clog2(NUM_SUBGRAPHS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_EMIT,
    ST_DONE
  } argmax_state_t;

endpackage

// File: rtl/gat_feat_argmax_cmp.sv
// Running signed maximum tracker for one node's feature stream.
// Exposes the value/index that include the word presented this cycle.
module argmax_cmp
  import gat_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CLASS_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_i,
  input  logic                  first_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CLASS_W-1:0]    idx_i,
  output logic [DATA_WIDTH-1:0] max_d_o,
  output logic [CLASS_W-1:0]    idx_d_o
);

  logic [DATA_WIDTH-1:0] max_q;
  logic [CLASS_W-1:0]    idx_q;

  // Strictly-greater update keeps the lowest index on ties.
  always_comb begin
    max_d_o = max_q;
    idx_d_o = idx_q;
    if (vld_i && (first_i || ($signed(data_i) > $signed(max_q)))) begin
      max_d_o = data_i;
      idx_d_o = idx_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d_o;
      idx_q <= idx_d_o;
    end
  end

endmodule

// File: rtl/gat_feat_argmax.sv
// Drains the feature BRAM node by node and emits each node's argmax class
// on a valid/ready port; read issue stops while a result is pending.
module gat_feat_argmax #(
  parameter int DATA_WIDTH         = gat_pkg::DATA_WIDTH,
  parameter int NUM_FEATURE_OUT    = gat_pkg::NUM_FEATURE_OUT,
  parameter int NUM_SUBGRAPHS      = gat_pkg::NUM_SUBGRAPHS,
  parameter int BRAM_RD_LAT        = gat_pkg::BRAM_RD_LAT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT),
  parameter int CLASS_W            = $clog2(NUM_FEATURE_OUT),
  parameter int NODE_W             = $clog2(NUM_SUBGRAPHS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  output logic                          feat_bram_enb,
  output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
  input  logic [DATA_WIDTH-1:0]         feat_bram_dout,
  output logic                          cls_vld_o,
  input  logic                          cls_rdy_i,
  output logic [CLASS_W-1:0]            cls_idx_o,
  output logic [NODE_W-1:0]             cls_node_o,
  output logic [DATA_WIDTH-1:0]         cls_max_o,
  output logic                          busy_o,
  output logic                          done_o
);
  import gat_pkg::*;

  localparam logic [CLASS_W-1:0] KLast    = CLASS_W'(NUM_FEATURE_OUT - 1);
  localparam logic [NODE_W-1:0]  NodeLast = NODE_W'(NUM_SUBGRAPHS - 1);

  argmax_state_t                 state_q;
  logic                          enb_q, vld_q, done_q;
  logic [NEW_FEATURE_ADDR_W-1:0] addr_q;
  logic [CLASS_W-1:0]            k_q, res_idx_q;
  logic [NODE_W-1:0]             node_q, res_node_q;
  logic [DATA_WIDTH-1:0]         res_max_q;

  logic [BRAM_RD_LAT-1:0]        vld_sr_q;
  logic [CLASS_W-1:0]            tag_sr_q [BRAM_RD_LAT];

  logic                          ret_vld, ret_first, ret_last;
  logic [CLASS_W-1:0]            ret_tag;
  logic [DATA_WIDTH-1:0]         best_max;
  logic [CLASS_W-1:0]            best_idx;

  assign ret_vld   = vld_sr_q[BRAM_RD_LAT-1];
  assign ret_tag   = tag_sr_q[BRAM_RD_LAT-1];
  assign ret_first = (ret_tag == '0);
  assign ret_last  = ret_vld && (ret_tag == KLast);

  // Tag pipe mirrors the BRAM latency so each returning word knows its index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr_q <= '0;
      for (int i = 0; i < BRAM_RD_LAT; i++) tag_sr_q[i] <= '0;
    end else begin
      vld_sr_q[0] <= enb_q;
      tag_sr_q[0] <= k_q;
      for (int i = 1; i < BRAM_RD_LAT; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
        tag_sr_q[i] <= tag_sr_q[i-1];
      end
    end
  end

  argmax_cmp #(
    .DATA_WIDTH(DATA_WIDTH),
    .CLASS_W   (CLASS_W)
  ) u_cmp (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (ret_vld),
    .first_i(ret_first),
    .data_i (feat_bram_dout),
    .idx_i  (ret_tag),
    .max_d_o(best_max),
    .idx_d_o(best_idx)
  );

  // addr_q runs continuously across nodes, so it always holds node*F + k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      enb_q      <= 1'b0;
      addr_q     <= '0;
      k_q        <= '0;
      node_q     <= '0;
      vld_q      <= 1'b0;
      res_idx_q  <= '0;
      res_node_q <= '0;
      res_max_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_READ;
            enb_q   <= 1'b1;
            addr_q  <= '0;
            k_q     <= '0;
            node_q  <= '0;
          end
        end
        ST_READ: begin
          addr_q <= addr_q + NEW_FEATURE_ADDR_W'(1);
          if (k_q == KLast) begin
            enb_q   <= 1'b0;
            k_q     <= '0;
            state_q <= ST_WAIT;
          end else begin
            k_q <= k_q + CLASS_W'(1);
          end
        end
        ST_WAIT: begin
          if (ret_last) begin
            res_idx_q  <= best_idx;
            res_max_q  <= best_max;
            res_node_q <= node_q;
            vld_q      <= 1'b1;
            state_q    <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (cls_rdy_i) begin
            vld_q <= 1'b0;
            if (node_q == NodeLast) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              node_q  <= node_q + NODE_W'(1);
              enb_q   <= 1'b1;
              state_q <= ST_READ;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign feat_bram_enb   = enb_q;
  assign feat_bram_addrb = addr_q;
  assign cls_vld_o       = vld_q;
  assign cls_idx_o       = res_idx_q;
  assign cls_node_o      = res_node_q;
  assign cls_max_o       = res_max_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_q;

endmodule
